// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion controller: one S-box lookup per cycle, 5 cycles per round key,
// 11 round keys held in registers and exposed both flat and through an indexed read port.
module key_schedule_ctrl (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [127:0]    key_in,
  input  logic [3:0]      rk_idx,
  output logic            busy,
  output logic            done,
  output logic            rk_valid,
  output logic [127:0]    rk_out,
  output logic [1407:0]   w
);

  typedef enum logic [1:0] {IDLE, SUB, XOR} state_t;

  // FIPS-197 forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t            state_q;
  logic [3:0]        round_q;
  logic [1:0]        j_q;
  logic [31:0]       tmp_q;
  logic [10:0][127:0] rk_q;
  logic              busy_q, done_q, valid_q;

  logic [3:0]   prev_idx;
  logic [127:0] prev_rk;
  logic [31:0]  rot, t;
  logic [7:0]   sub_out;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rk_new_d;

  always_comb begin
    prev_idx = round_q - 4'd1;
    prev_rk  = (prev_idx > 4'd10) ? '0 : rk_q[prev_idx];
    rot      = {prev_rk[23:0], prev_rk[31:24]};
    sub_out  = sbox(rot[{~j_q, 3'b000} +: 8]);
    t        = tmp_q ^ {rcon(round_q), 24'h0};
    n0       = prev_rk[127:96] ^ t;
    n1       = prev_rk[95:64]  ^ n0;
    n2       = prev_rk[63:32]  ^ n1;
    n3       = prev_rk[31:0]   ^ n2;
    rk_new_d = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      j_q     <= '0;
      tmp_q   <= '0;
      rk_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          rk_q[0] <= key_in;
          round_q <= 4'd1;
          j_q     <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= SUB;
        end
        SUB: begin
          // tmp byte j lands in the same lane it was read from in the rotated word
          tmp_q[{~j_q, 3'b000} +: 8] <= sub_out;
          j_q <= j_q + 2'd1;
          if (j_q == 2'd3) state_q <= XOR;
        end
        XOR: begin
          rk_q[round_q] <= rk_new_d;
          if (round_q == 4'd10) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            round_q <= round_q + 4'd1;
            j_q     <= '0;
            state_q <= SUB;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rk_valid = valid_q && (rk_idx <= 4'd10);
  assign rk_out   = (rk_idx <= 4'd10) ? rk_q[rk_idx] : '0;

  for (genvar i = 0; i < 11; i++) begin : g_flat
    assign w[1407-128*i -: 128] = rk_q[i];
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench for key_schedule_ctrl: stimulus queues expected key sets at each
// accepted start, a monitor checks them against w and the done latency on every done pulse.
module tb_key_schedule_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [127:0]  key_in = '0;
  logic [3:0]    rk_idx = '0;
  logic          busy, done, rk_valid;
  logic [127:0]  rk_out;
  logic [1407:0] w;

  key_schedule_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rk_idx(rk_idx),
    .busy(busy), .done(done), .rk_valid(rk_valid), .rk_out(rk_out), .w(w)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] rk0, rk1, rk10;
    int           k;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding start
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 128'd1, 128'd0);
      end else begin
        e = q.pop_front();
        chk("done_latency", 128'(cyc - e.k), 128'd50);
        chk("w_rk0",  w[1407:1280], e.rk0);
        chk("w_rk1",  w[1279:1152], e.rk1);
        chk("w_rk10", w[127:0],     e.rk10);
      end
    end
  end

  task automatic go(input logic [127:0] key, input logic [127:0] e1, input logic [127:0] e10,
                    input bit hold);
    exp_t e;
    key_in = key;
    start  = 1'b1;
    @(posedge clk);
    #1;
    e.rk0 = key; e.rk1 = e1; e.rk10 = e10; e.k = cyc;
    q.push_back(e);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_idle(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      nbusy++;
    end
    chk("idle_reached", 128'(busy), 128'd0);
  endtask

  task automatic read_rk(input logic [3:0] idx, input logic [127:0] exp, input logic vexp,
                         input string name);
    rk_idx = idx;
    #1;
    chk({name, "_out"}, rk_out, exp);
    chk({name, "_valid"}, 128'(rk_valid), 128'(vexp));
  endtask

  initial begin
    int nb;
    int d0;

    // reset state
    #12;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_valid", 128'(rk_valid), 128'd0);
    chk("rst_w_zero", 128'(w == '0), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 vector
    go(FIPS_K0, FIPS_K1, FIPS_K10, 1'b0);
    @(negedge clk);
    chk("busy_after_start", 128'(busy), 128'd1);
    read_rk(4'd0, FIPS_K0, 1'b0, "mid_rk0");
    wait_idle(nb);
    chk("busy_cycles", 128'(nb + 1), 128'd50);
    read_rk(4'd0, FIPS_K0, 1'b1, "fips_rk0");
    read_rk(4'd1, FIPS_K1, 1'b1, "fips_rk1");
    read_rk(4'd10, FIPS_K10, 1'b1, "fips_rk10");
    read_rk(4'd11, 128'd0, 1'b0, "idx11");
    read_rk(4'd15, 128'd0, 1'b0, "idx15");
    @(negedge clk);
    chk("done_single", 128'(done), 128'd0);

    // all-zero key
    go(128'd0, ZERO_K1, ZERO_K10, 1'b0);
    wait_idle(nb);
    read_rk(4'd1, ZERO_K1, 1'b1, "zero_rk1");
    read_rk(4'd10, ZERO_K10, 1'b1, "zero_rk10");
    chk("zero_w0", w[1407:1280], 128'd0);
    @(negedge clk);

    // start pulses mid-run are ignored
    d0 = done_cnt;
    go(FIPS_K0, FIPS_K1, FIPS_K10, 1'b0);
    repeat (9) @(negedge clk);
    key_in = 128'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    key_in = 128'h0123456789abcdef0123456789abcdef; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(nb);
    repeat (5) @(negedge clk);
    chk("one_done_pulse", 128'(done_cnt - d0), 128'd1);
    read_rk(4'd10, FIPS_K10, 1'b1, "ign_rk10");

    // reset mid-run aborts without done
    d0 = done_cnt;
    go(128'd0, ZERO_K1, ZERO_K10, 1'b0);
    repeat (24) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_valid", 128'(rk_valid), 128'd0);
    chk("abort_w_zero", 128'(w == '0), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_no_done", 128'(done_cnt - d0), 128'd0);
    go(FIPS_K0, FIPS_K1, FIPS_K10, 1'b0);
    wait_idle(nb);
    read_rk(4'd1, FIPS_K1, 1'b1, "post_rst_rk1");
    @(negedge clk);

    // back-to-back with start held through done
    go(FIPS_K0, FIPS_K1, FIPS_K10, 1'b1);
    key_in = 128'd0;
    wait_idle(nb);
    chk("b2b_done_seen", 128'(done), 128'd1);
    go(128'd0, ZERO_K1, ZERO_K10, 1'b0);
    @(negedge clk);
    chk("b2b_busy", 128'(busy), 128'd1);
    read_rk(4'd0, 128'd0, 1'b0, "b2b_mid_rk0");
    wait_idle(nb);
    read_rk(4'd10, ZERO_K10, 1'b1, "b2b_rk10");
    repeat (3) @(negedge clk);

    chk("queue_drained", 128'(q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
